// File: rtl/rx_sram_ctrl.sv
// Receive-side scheduler: pops Rx FIFO entries, stores error-free bytes to
// consecutive SRAM addresses and tallies discarded entries in flags and a counter.
module rx_sram_ctrl #(
    parameter int ADDR_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    input  logic [11:0]       fifo_dout,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_wdata,
    output logic [ADDR_W:0]   byte_cnt,
    output logic              buf_full,
    output logic              oe_flag,
    output logic              be_flag,
    output logic              fe_flag,
    output logic [ERR_W-1:0]  err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CHECK,
        WRITE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] wr_ptr;
    logic              entry_bad;
    logic              unused_parity;

    assign entry_bad     = |fifo_dout[11:9];
    assign unused_parity = fifo_dout[8];
    assign sram_addr     = wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Strobes come straight from the state; clr forces the walk back to IDLE
    // except in WRITE, where the write strobe is already committed.
    always_comb begin
        state_next = state;
        fifo_rd    = 1'b0;
        sram_we    = 1'b0;
        case (state)
            IDLE: begin
                if (!clr && en && !fifo_empty && !buf_full) begin
                    state_next = READ;
                end
            end
            READ: begin
                fifo_rd    = 1'b1;
                state_next = clr ? IDLE : CHECK;
            end
            CHECK: begin
                state_next = (clr || entry_bad) ? IDLE : WRITE;
            end
            WRITE: begin
                sram_we    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // clr outranks every increment, so a write in flight still lands but is not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            sram_wdata <= '0;
            byte_cnt   <= '0;
            buf_full   <= 1'b0;
            oe_flag    <= 1'b0;
            be_flag    <= 1'b0;
            fe_flag    <= 1'b0;
            err_cnt    <= '0;
        end else if (clr) begin
            wr_ptr   <= '0;
            byte_cnt <= '0;
            buf_full <= 1'b0;
            oe_flag  <= 1'b0;
            be_flag  <= 1'b0;
            fe_flag  <= 1'b0;
            err_cnt  <= '0;
        end else begin
            case (state)
                CHECK: begin
                    if (entry_bad) begin
                        oe_flag <= oe_flag | fifo_dout[9];
                        be_flag <= be_flag | fifo_dout[10];
                        fe_flag <= fe_flag | fifo_dout[11];
                        if (err_cnt != '1) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                    end else begin
                        sram_wdata <= fifo_dout[7:0];
                    end
                end
                WRITE: begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    byte_cnt <= byte_cnt + 1'b1;
                    buf_full <= ((byte_cnt + 1'b1) == DEPTH_CNT);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_sram_ctrl.sv
// Self-checking bench for rx_sram_ctrl: a queue-backed Rx FIFO model, a write
// monitor, table vectors, corner-case sequences and randomized rounds.
module tb_rx_sram_ctrl;

    localparam int ADDR_W  = 2;
    localparam int ERR_W   = 4;
    localparam int DEPTH   = 4;
    localparam int ERR_MAX = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en  = 1'b0;
    logic              clr = 1'b0;
    logic              fifo_empty = 1'b1;
    logic              fifo_rd;
    logic [11:0]       fifo_dout = '0;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [7:0]        sram_wdata;
    logic [ADDR_W:0]   byte_cnt;
    logic              buf_full;
    logic              oe_flag;
    logic              be_flag;
    logic              fe_flag;
    logic [ERR_W-1:0]  err_cnt;

    rx_sram_ctrl #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .fifo_empty(fifo_empty),
        .fifo_rd   (fifo_rd),
        .fifo_dout (fifo_dout),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_wdata(sram_wdata),
        .byte_cnt  (byte_cnt),
        .buf_full  (buf_full),
        .oe_flag   (oe_flag),
        .be_flag   (be_flag),
        .fe_flag   (fe_flag),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    logic [11:0] fifo_q[$];
    bit   toggle_mode  = 1'b0;
    bit   toggle_phase = 1'b0;
    bit   prev_rd      = 1'b0;
    int   cycle = 0;
    int   rd_count = 0;
    int   we_count = 0;
    int   last_rd_cycle = -100;
    int   last_we_cycle = -100;
    int   rd_empty_viol = 0;
    int   rd_back_viol  = 0;
    int   underflow     = 0;
    int   wlog_addr[$];
    int   wlog_data[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    // FIFO model and write monitor, evaluated mid-cycle away from the DUT edge.
    always @(negedge clk) begin
        cycle++;
        if (fifo_rd) begin
            rd_count++;
            last_rd_cycle = cycle;
            if (fifo_empty) rd_empty_viol++;
            if (prev_rd) rd_back_viol++;
            if (fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
            else underflow++;
        end
        if (sram_we) begin
            we_count++;
            last_we_cycle = cycle;
            wlog_addr.push_back(int'(sram_addr));
            wlog_data.push_back(int'(sram_wdata));
        end
        prev_rd = fifo_rd;
        toggle_phase = ~toggle_phase;
        fifo_empty = (fifo_q.size() == 0) || (toggle_mode && toggle_phase);
    end

    typedef struct {
        bit          do_clr;
        logic [11:0] entry;
        int          exp_we;
        int          exp_addr;
        int          exp_data;
        int          exp_bc;
        int          exp_flags;
        int          exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    function automatic int flags_now();
        return int'({fe_flag, be_flag, oe_flag});
    endfunction

    task automatic wait_rd_negedge(output bit found);
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (fifo_rd) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_we_count(input int target, output bit found);
        found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (we_count >= target) begin
                found = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic applyStimulus(input vec_t v, output int w0, output int r0);
        if (v.do_clr) pulse_clr();
        w0 = we_count;
        r0 = rd_count;
        fifo_q.push_back(v.entry);
        for (int k = 0; k < 20; k++) begin
            if (rd_count > r0) break;
            tick(1);
        end
        tick(4);
    endtask

    task automatic checkOutput(input vec_t v, input int w0, input int r0);
        check("vec_pop", rd_count - r0, 1);
        check("vec_we", we_count - w0, v.exp_we);
        if (v.exp_we != 0 && we_count > w0) begin
            check("vec_addr", wlog_addr[wlog_addr.size()-1], v.exp_addr);
            check("vec_data", wlog_data[wlog_data.size()-1], v.exp_data);
            check("vec_latency", last_we_cycle - last_rd_cycle, 2);
        end
        check("vec_byte_cnt", int'(byte_cnt), v.exp_bc);
        check("vec_flags", flags_now(), v.exp_flags);
        check("vec_err_cnt", int'(err_cnt), v.exp_err);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fifo_rd"}, int'(fifo_rd), 0);
        check({tag, "_sram_we"}, int'(sram_we), 0);
        check({tag, "_sram_addr"}, int'(sram_addr), 0);
        check({tag, "_sram_wdata"}, int'(sram_wdata), 0);
        check({tag, "_byte_cnt"}, int'(byte_cnt), 0);
        check({tag, "_buf_full"}, int'(buf_full), 0);
        check({tag, "_flags"}, flags_now(), 0);
        check({tag, "_err_cnt"}, int'(err_cnt), 0);
    endtask

    // Reference: entries are taken in order until DEPTH good bytes are stored.
    task automatic randomRound();
        logic [11:0] e;
        int ents[$];
        int ea[$];
        int ed[$];
        int n, w0, stored, err, flags, consumed, bits;
        en = 1'b0;
        tick(6);
        fifo_q.delete();
        pulse_clr();
        w0 = wlog_addr.size();
        n = $urandom_range(1, 8);
        for (int i = 0; i < n; i++) begin
            e = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 2) != 0) e[11:9] = 3'b000;
            ents.push_back(int'(e));
            fifo_q.push_back(e);
        end
        toggle_mode = ($urandom_range(0, 1) == 1);
        en = 1'b1;
        tick(90);
        en = 1'b0;
        tick(2);
        toggle_mode = 1'b0;
        stored = 0; err = 0; flags = 0; consumed = 0;
        foreach (ents[i]) begin
            if (stored == DEPTH) break;
            consumed++;
            bits = (ents[i] >> 9) & 7;
            if (bits != 0) begin
                flags = flags | bits;
                if (err < ERR_MAX) err++;
            end else begin
                ea.push_back(stored % DEPTH);
                ed.push_back(ents[i] & 255);
                stored++;
            end
        end
        check("rnd_writes", wlog_addr.size() - w0, ea.size());
        for (int i = 0; i < ea.size() && (w0 + i) < wlog_addr.size(); i++) begin
            check("rnd_addr", wlog_addr[w0+i], ea[i]);
            check("rnd_data", wlog_data[w0+i], ed[i]);
        end
        check("rnd_byte_cnt", int'(byte_cnt), stored);
        check("rnd_buf_full", int'(buf_full), (stored == DEPTH) ? 1 : 0);
        check("rnd_flags", flags_now(), flags);
        check("rnd_err_cnt", int'(err_cnt), err);
        check("rnd_left", fifo_q.size(), n - consumed);
        fifo_q.delete();
    endtask

    initial begin
        int  w0, r0, w1, r1;
        bit  found;

        vecs[0] = '{1'b0, 12'h041, 1, 0, 'h41, 1, 0, 0};
        vecs[1] = '{1'b0, 12'h042, 1, 1, 'h42, 2, 0, 0};
        vecs[2] = '{1'b0, 12'h043, 1, 2, 'h43, 3, 0, 0};
        vecs[3] = '{1'b1, 12'h2AA, 0, 0, 0,    0, 1, 1};
        vecs[4] = '{1'b0, 12'h555, 0, 0, 0,    0, 3, 2};
        vecs[5] = '{1'b0, 12'h8FF, 0, 0, 0,    0, 7, 3};
        vecs[6] = '{1'b0, 12'hE00, 0, 0, 0,    0, 7, 4};
        vecs[7] = '{1'b0, 12'h1A5, 1, 0, 'hA5, 1, 7, 4};

        tick(2);
        check_all_zero("rst_held");
        rst = 1'b0;
        tick(1);
        check_all_zero("rst_released");

        en = 1'b1;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i], w0, r0);
            checkOutput(vecs[i], w0, r0);
        end

        // Buffer fills, popping stops, clr restarts at address 0.
        en = 1'b0;
        tick(2);
        pulse_clr();
        w0 = wlog_addr.size();
        r0 = rd_count;
        for (int i = 0; i < 6; i++) fifo_q.push_back(12'h010 + 12'(i));
        en = 1'b1;
        tick(40);
        check("full_writes", wlog_addr.size() - w0, 4);
        for (int i = 0; i < 4 && (w0 + i) < wlog_addr.size(); i++) begin
            check("full_addr", wlog_addr[w0+i], i);
            check("full_data", wlog_data[w0+i], 'h10 + i);
        end
        check("full_byte_cnt", int'(byte_cnt), 4);
        check("full_buf_full", int'(buf_full), 1);
        check("full_left", fifo_q.size(), 2);
        r1 = rd_count;
        tick(10);
        check("full_no_pop", rd_count - r1, 0);
        check("full_pops", rd_count - r0, 4);
        pulse_clr();
        tick(30);
        check("refill_writes", wlog_addr.size() - w0, 6);
        if (wlog_addr.size() >= w0 + 6) begin
            check("refill_addr0", wlog_addr[w0+4], 0);
            check("refill_data0", wlog_data[w0+4], 'h14);
            check("refill_addr1", wlog_addr[w0+5], 1);
            check("refill_data1", wlog_data[w0+5], 'h15);
        end
        check("refill_byte_cnt", int'(byte_cnt), 2);
        check("refill_buf_full", int'(buf_full), 0);

        // Error counter saturates and holds.
        en = 1'b0;
        tick(2);
        pulse_clr();
        w0 = we_count;
        for (int i = 0; i < 20; i++) fifo_q.push_back(12'h800 | 12'(i));
        en = 1'b1;
        tick(75);
        check("sat_err_cnt", int'(err_cnt), ERR_MAX);
        check("sat_flags", flags_now(), 4);
        check("sat_byte_cnt", int'(byte_cnt), 0);
        check("sat_no_write", we_count - w0, 0);
        check("sat_left", fifo_q.size(), 0);
        fifo_q.push_back(12'h200);
        fifo_q.push_back(12'h200);
        tick(10);
        check("sat_hold", int'(err_cnt), ERR_MAX);
        check("sat_flags2", flags_now(), 5);

        // en dropped during READ: entry in flight still written, then no pops.
        en = 1'b0;
        tick(2);
        pulse_clr();
        fifo_q.push_back(12'h0C1);
        fifo_q.push_back(12'h0C2);
        w0 = we_count;
        r0 = rd_count;
        en = 1'b1;
        wait_rd_negedge(found);
        en = 1'b0;
        check("en_rd_seen", int'(found), 1);
        tick(10);
        check("en_pops", rd_count - r0, 1);
        check("en_writes", we_count - w0, 1);
        check("en_data", wlog_data[wlog_data.size()-1], 'hC1);
        check("en_left", fifo_q.size(), 1);
        fifo_q.delete();

        // clr during WRITE: write lands at old address, counters end at 0.
        pulse_clr();
        fifo_q.push_back(12'h07D);
        fifo_q.push_back(12'h07E);
        w0 = we_count;
        en = 1'b1;
        found = 1'b0;
        w1 = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sram_we) begin
                w1++;
                if (w1 == 2) begin
                    found = 1'b1;
                    break;
                end
            end
        end
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clrw_seen", int'(found), 1);
        check("clrw_writes", we_count - w0, 2);
        check("clrw_addr", wlog_addr[wlog_addr.size()-1], 1);
        check("clrw_data", wlog_data[wlog_data.size()-1], 'h7E);
        check("clrw_byte_cnt", int'(byte_cnt), 0);
        fifo_q.push_back(12'h07F);
        tick(8);
        check("clrw_next_addr", wlog_addr[wlog_addr.size()-1], 0);
        check("clrw_next_data", wlog_data[wlog_data.size()-1], 'h7F);
        check("clrw_next_cnt", int'(byte_cnt), 1);

        // Asynchronous reset during CHECK.
        en = 1'b0;
        tick(2);
        pulse_clr();
        fifo_q.push_back(12'hE00);
        fifo_q.push_back(12'h033);
        fifo_q.push_back(12'h044);
        w0 = we_count;
        en = 1'b1;
        wait_we_count(w0 + 1, found);
        check("rstc_first_write", int'(found), 1);
        wait_rd_negedge(found);
        check("rstc_rd_seen", int'(found), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_check");
        w1 = we_count;
        tick(3);
        check("rstc_no_we", we_count - w1, 0);
        rst = 1'b0;
        en = 1'b0;
        tick(2);
        fifo_q.delete();

        for (int r = 0; r < 12; r++) randomRound();

        check("rd_while_empty", rd_empty_viol, 0);
        check("rd_back_to_back", rd_back_viol, 0);
        check("fifo_underflow", underflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/rx_sram_ctrl.md
# rx_sram_ctrl

Receive-side scheduler between the UART Rx FIFO and the SRAM. It pops 12-bit Rx FIFO entries, classifies each by its error bits, writes error-free data bytes to consecutive SRAM addresses, and discards erroneous entries. Discarded entries are recorded in sticky per-type flags and a saturating error counter. It is the only SRAM write master on the receive path.

## Interface
- ADDR_W, 8, SRAM address width; buffer depth DEPTH = 2**ADDR_W bytes
- ERR_W, 8, width of the error counter
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  enables popping new entries
- clr  in  1  synchronous clear of pointer, counters and flags
- fifo_empty  in  1  Rx FIFO empty
- fifo_rd  out  1  Rx FIFO pop strobe, one cycle per entry
- fifo_dout  in  12  Rx FIFO entry, valid the cycle after fifo_rd
  - [7:0] data
  - [8] parity, not checked here
  - [9] OE
  - [10] BE
  - [11] FE
- sram_we  out  1  SRAM write strobe
- sram_addr  out  ADDR_W  SRAM write address
- sram_wdata  out  8  SRAM write data
- byte_cnt  out  ADDR_W+1  good bytes stored since reset or clr
- buf_full  out  1  byte_cnt == DEPTH
- oe_flag, be_flag, fe_flag  out  1 each  sticky error flags
- err_cnt  out  ERR_W  discarded entries, saturating

## Operation
- States:
  - IDLE: go to READ when en && !fifo_empty && !buf_full; otherwise stay.
  - READ: fifo_rd = 1; go to CHECK.
  - CHECK: capture fifo_dout.
    - If fifo_dout[11:9] != 0: discard. Set each flag whose bit is 1 (several in one entry are all set). err_cnt += 1, saturating at all-ones. Go to IDLE.
    - Otherwise: latch fifo_dout[7:0] into the write-data register and go to WRITE.
  - WRITE: sram_we = 1, sram_addr = wr_ptr, sram_wdata = latched byte. Then wr_ptr += 1 (wraps DEPTH-1 -> 0), byte_cnt += 1. Go to IDLE.
- fifo_rd and sram_we are decoded from state only; every other output is registered.
- Each entry is counted exactly once: stored or discarded, never both.
- buf_full:
  - Blocks new pops only; an entry already in flight completes.
  - Cleared only by clr or rst.
  - A wrapped wr_ptr does not overwrite data while buf_full is set, because popping stops first.
- en low: an entry in flight completes; the block then holds in IDLE.
- clr, with priority over all increments in its cycle:
  - wr_ptr, byte_cnt, err_cnt and the flags go to 0; FSM goes to IDLE.
  - clr during WRITE: the write still occurs at the old address, but counters end at 0.
  - clr during READ: the pop occurs and the entry is dropped uncounted.
  - clr during CHECK: the captured entry is dropped.
- rst (asynchronous):
  - Outputs: fifo_rd = 0, sram_we = 0, sram_addr = 0, sram_wdata = 0, byte_cnt = 0, buf_full = 0, all flags = 0, err_cnt = 0.
  - Internal: wr_ptr = 0, FSM = IDLE.
  - Mid-operation reset aborts any pending pop or write with no further strobes.

## Timing
- Good entry: 4 cycles (IDLE, READ, CHECK, WRITE). fifo_rd in cycle n, sram_we in cycle n+2.
- Bad entry: 3 cycles (IDLE, READ, CHECK). Flags and err_cnt update at the end of cycle n+1.
- Sustained throughput: 1 good byte per 4 clocks.
- fifo_empty is sampled only in IDLE. fifo_rd never asserts while fifo_empty = 1 in that cycle, and never on two consecutive cycles.
- byte_cnt and buf_full update on the clock edge ending WRITE. buf_full is visible in the next IDLE, so no extra pop is issued.

## Test plan
- Three clean entries 0x041, 0x042, 0x043 after reset, en = 1:
  - SRAM[0..2] = 0x41, 0x42, 0x43.
  - byte_cnt = 3, err_cnt = 0, flags 0.
  - sram_we exactly 2 cycles after each fifo_rd.
- Entries 0x2AA (OE), 0x555 (BE), 0x8FF (FE), 0xE00 (all three):
  - No sram_we.
  - oe_flag = be_flag = fe_flag = 1, err_cnt = 4, byte_cnt = 0.
- ADDR_W = 2, six clean entries:
  - Four written to addresses 0..3.
  - buf_full = 1 and byte_cnt = 4; fifo_rd stays 0 with two entries remaining.
  - clr, then the two remaining entries are written to addresses 0 and 1.
- ERR_W = 2, five erroneous entries: err_cnt = 3 and holds.
- Interrupted operation:
  - en dropped in the READ cycle: the entry is still written, then no further fifo_rd.
  - clr in the WRITE cycle: write occurs, byte_cnt = 0 afterwards.
  - rst asserted in the CHECK cycle: all outputs 0 immediately, no sram_we.
- fifo_empty toggling every cycle with en = 1: no fifo_rd while empty, every popped entry handled exactly once.
